// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned REG_AW = $clog2(NREG);

   localparam logic [REG_AW-1:0] REG_X0 = '0;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbHeld  = 2'd1,
      ArbStall = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy vector for LLU destinations in flight. Set and clear of the
// same register in one cycle resolves to set (a new op has been dispatched).
module rf_scoreboard
   import rf_write_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   output logic [NREG-1:0]   busy
);

   logic [NREG-1:0] busy_d, busy_q;

   // Next busy vector: clear first so a same-cycle set overrides it.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      if (set_en) busy_d[set_idx] = 1'b1;
   end

   // Busy register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and a
// long-latency unit whose single result is buffered until the port is free.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              llu_issue,
   input  logic [REG_AW-1:0] llu_issue_rd,
   input  logic              llu_valid,
   input  logic [REG_AW-1:0] llu_rd,
   input  logic [XLEN-1:0]   llu_data,
   output logic              llu_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic [NREG-1:0]   busy,
   output logic              stall_o
);

   localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

   arb_state_e        state_d, state_q;
   logic [3:0]        wait_cnt_d, wait_cnt_q;
   logic [REG_AW-1:0] held_rd_d, held_rd_q;
   logic [XLEN-1:0]   held_data_d, held_data_q;

   logic held_v;
   logic wb_req;
   logic accept;
   logic drain;

   assign held_v    = (state_q != ArbIdle);
   // A write to x0 is not a port request at all.
   assign wb_req    = wb_we && (wb_rd != REG_X0);
   assign llu_ready = ~held_v;
   // Results for x0 are acknowledged but never buffered.
   assign accept    = llu_valid && llu_ready && (llu_rd != REG_X0);
   assign drain     = held_v && !wb_req;
   assign stall_o   = (state_q == ArbStall);

   // Next-state: buffer capture, starvation counting and drain.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      held_rd_d   = held_rd_q;
      held_data_d = held_data_q;
      unique case (state_q)
         ArbIdle: begin
            if (accept) begin
               state_d     = ArbHeld;
               wait_cnt_d  = '0;
               held_rd_d   = llu_rd;
               held_data_d = llu_data;
            end
         end
         ArbHeld: begin
            if (drain) begin
               state_d = ArbIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
               if (wait_cnt_q == WaitLast) state_d = ArbStall;
            end
         end
         ArbStall: begin
            if (drain) state_d = ArbIdle;
         end
         default: state_d = ArbIdle;
      endcase
   end

   // Arbiter state and buffered LLU entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ArbIdle;
         wait_cnt_q  <= '0;
         held_rd_q   <= '0;
         held_data_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         held_rd_q   <= held_rd_d;
         held_data_q <= held_data_d;
      end
   end

   // Write-port mux: writeback first, then the buffered entry, else idle.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (wb_req) begin
         rf_we    = 1'b1;
         rf_waddr = wb_rd;
         rf_wdata = wb_data;
      end else if (held_v) begin
         rf_we    = 1'b1;
         rf_waddr = held_rd_q;
         rf_wdata = held_data_q;
      end
   end

   rf_scoreboard u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (llu_issue && (llu_issue_rd != REG_X0)),
      .set_idx (llu_issue_rd),
      .clr_en  (drain),
      .clr_idx (held_rd_q),
      .busy    (busy)
   );

   // Decode must never let writeback target a register with an LLU write pending.
   wb_to_busy_reg : assert property (@(posedge clk) disable iff (!rst_n)
      !(wb_req && busy[wb_rd]));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized bench for rf_write_arbiter against a transaction-level model.
module tb_rf_write_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        llu_issue = 1'b0;
   logic [4:0]  llu_issue_rd = '0;
   logic        llu_valid = 1'b0;
   logic [4:0]  llu_rd = '0;
   logic [31:0] llu_data = '0;
   logic        llu_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy;
   logic        stall_o;

   rf_write_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .llu_issue    (llu_issue),
      .llu_issue_rd (llu_issue_rd),
      .llu_valid    (llu_valid),
      .llu_rd       (llu_rd),
      .llu_data     (llu_data),
      .llu_ready    (llu_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .busy         (busy),
      .stall_o      (stall_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference state: an optional pending result and how long it has been starved.
   bit          m_held;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   int          m_blocked;
   logic [31:0] m_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_rd = '0; m_data = '0; m_blocked = 0; m_busy = '0;
   endtask

   function automatic bit model_stall();
      return m_held && (m_blocked >= MAX_WAIT);
   endfunction

   // One clock of stimulus: drive, check combinational outputs, advance the model.
   task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic iss, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      bit          req;
      bit          was_held;
      logic        e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      @(negedge clk);
      wb_we = we; wb_rd = rd; wb_data = d;
      llu_issue = iss; llu_issue_rd = ird;
      llu_valid = lv; llu_rd = lrd; llu_data = ld;
      #1;
      req = we && (rd != 0);
      if (req) begin
         e_we = 1'b1; e_addr = rd; e_data = d;
      end else if (m_held) begin
         e_we = 1'b1; e_addr = m_rd; e_data = m_data;
      end else begin
         e_we = 1'b0; e_addr = '0; e_data = '0;
      end
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
      check("llu_ready", 32'(llu_ready), 32'(!m_held));
      check("stall_o", 32'(stall_o), 32'(model_stall()));
      check("busy", busy, m_busy);
      was_held = m_held;
      if (m_held) begin
         if (!req) begin
            m_held = 0;
            m_busy[m_rd] = 1'b0;
         end else begin
            m_blocked++;
         end
      end
      if (iss && ird != 0) m_busy[ird] = 1'b1;
      if (!was_held && lv && lrd != 0) begin
         m_held = 1; m_rd = lrd; m_data = ld; m_blocked = 0;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #12;
      check("reset_rf_we", 32'(rf_we), 32'd0);
      check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
      check("reset_rf_wdata", rf_wdata, 32'd0);
      check("reset_llu_ready", 32'(llu_ready), 32'd1);
      check("reset_stall", 32'(stall_o), 32'd0);
      check("reset_busy", busy, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Writeback alone goes straight to the port.
      step(1, 5, 32'hA5, 0, 0, 0, 0, 0);

      // LLU result on an idle port: buffered, written next cycle, busy cleared after.
      step(0, 0, 0, 1, 7, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 7, 32'h1234);
      idle();
      idle();
      check("t2_busy7", 32'(busy[7]), 32'd0);

      // Contention below the starvation limit.
      step(0, 0, 0, 1, 3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 3, 32'h3333);
      for (int i = 0; i < 3; i++) step(1, 10, 32'h1000 + i, 0, 0, 0, 0, 0);
      idle();
      idle();

      // Starvation: continuous writeback forces a stall, then the entry drains.
      step(0, 0, 0, 1, 4, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 4, 32'h4444);
      for (int i = 0; i < MAX_WAIT + 1; i++) step(1, 11, 32'h2000 + i, 0, 0, 0, 0, 0);
      check("t4_stall_seen", 32'(stall_o), 32'd1);
      idle();
      idle();

      // x0 traffic never reaches the port or the buffer.
      step(1, 0, 32'hDEAD, 1, 0, 1, 0, 32'hBEEF);
      idle();

      // Randomized traffic honouring the decode and stall protocol.
      for (int n = 0; n < 1500; n++) begin
         logic       we;
         logic [4:0] rd;
         we = ($urandom_range(0, 9) < 6);
         if (model_stall() && $urandom_range(0, 3) != 0) we = 1'b0;
         rd = 5'($urandom_range(0, 31));
         if (m_busy[rd]) rd = 5'd0;
         step(we, rd, $urandom,
              ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom);
      end

      // Asynchronous reset while stalled with busy bits set.
      step(0, 0, 0, 1, 9, 0, 0, 0);
      step(0, 0, 0, 1, 12, 1, 9, 32'h9999);
      for (int i = 0; i < MAX_WAIT + 1; i++) step(1, 13, 32'h3000 + i, 0, 0, 0, 0, 0);
      wb_we = 1'b0; llu_issue = 1'b0; llu_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_stall", 32'(stall_o), 32'd0);
      check("t6_busy", busy, 32'd0);
      check("t6_llu_ready", 32'(llu_ready), 32'd1);
      check("t6_rf_we", 32'(rf_we), 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      step(0, 0, 0, 0, 0, 1, 21, 32'h2121);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
